// File: rtl/apb_cmd_master.sv
// APB command master: one command in flight, walked through IDLE -> SETUP -> ACCESS.
// Define APB_TIMEOUT_EN to abort an ACCESS phase after TIMEOUT not-ready cycles.
module apb_cmd_master #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                      PCLK,
    input  logic                      PRESETn,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]   cmd_strb,
    output logic                      rsp_valid,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic                      rsp_err,
    output logic                      PSEL,
    output logic                      PENABLE,
    output logic                      PWRITE,
    output logic [ADDR_WIDTH-1:0]     PADDR,
    output logic [DATA_WIDTH/8-1:0]   PSTRB,
    output logic [DATA_WIDTH-1:0]     PWDATA,
    input  logic [DATA_WIDTH-1:0]     PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic                    cmd_ready_q, cmd_ready_d;
    logic                    psel_q, psel_d;
    logic                    penable_q, penable_d;
    logic                    pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic [STRB_WIDTH-1:0]   pstrb_q, pstrb_d;
    logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_err_q, rsp_err_d;

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]        tmo_cnt_q, tmo_cnt_d;
`endif

    // NOTE: every signal gets its hold value first so no path through this block can infer a latch.
    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pstrb_d     = pstrb_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
`ifdef APB_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    state_d   = SETUP;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    pwrite_d  = cmd_write;
                    paddr_d   = cmd_addr;
                    pstrb_d   = cmd_write ? cmd_strb : '0;
                    pwdata_d  = cmd_wdata;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
`ifdef APB_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
            end
            ACCESS: begin
                if (PREADY) begin
                    state_d     = IDLE;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = PSLVERR;
                    rsp_rdata_d = pwrite_q ? '0 : PRDATA;
                end
`ifdef APB_TIMEOUT_EN
                else begin
                    tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
                    // This cycle's increment makes the count reach TIMEOUT.
                    if (tmo_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        state_d     = IDLE;
                        psel_d      = 1'b0;
                        penable_d   = 1'b0;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end
                end
`endif
            end
            default: begin
                state_d   = IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase

        cmd_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pstrb_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pstrb_q     <= pstrb_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

`ifdef APB_TIMEOUT_EN
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) tmo_cnt_q <= '0;
        else          tmo_cnt_q <= tmo_cnt_d;
    end
`endif

    assign cmd_ready = cmd_ready_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PSTRB     = pstrb_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: behavioural APB slave, byte-strobed reference memory,
// directed and random commands, reset abort, and timeout when APB_TIMEOUT_EN is defined.
module tb_apb_cmd_master;

    localparam int TIMEOUT = 16;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [7:0]  cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_strb = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        PSEL, PENABLE, PWRITE;
    logic [7:0]  PADDR;
    logic [3:0]  PSTRB;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA = '0;
    logic        PREADY = 1'b0;
    logic        PSLVERR = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    // Slave side: its own storage, wait-state setting and a hang switch.
    logic [31:0] slv_mem [256];
    int          slave_waits = 0;
    bit          slave_hang  = 1'b0;
    int          slave_cnt   = 0;

    // Reference model: what memory should hold after each completed command.
    logic [31:0] ref_mem [256];
    logic [31:0] last_rdata;
    logic        last_err;

    apb_cmd_master #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .TIMEOUT(TIMEOUT)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PSTRB(PSTRB), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    // Slave responds on the falling edge; outside ACCESS it drives random noise.
    always @(negedge PCLK) begin
        if (PSEL && PENABLE) begin
            if (!slave_hang && slave_cnt == slave_waits) begin
                PREADY  = 1'b1;
                PSLVERR = (PADDR >= 8'hC0);
                PRDATA  = slv_mem[PADDR];
                if (PWRITE && !PSLVERR)
                    for (int i = 0; i < 4; i++)
                        if (PSTRB[i]) slv_mem[PADDR][8*i +: 8] = PWDATA[8*i +: 8];
            end else begin
                PREADY    = 1'b0;
                PSLVERR   = 1'($urandom);
                PRDATA    = $urandom;
                slave_cnt = slave_cnt + 1;
            end
        end else begin
            slave_cnt = 0;
            PREADY    = 1'($urandom);
            PSLVERR   = 1'($urandom);
            PRDATA    = $urandom;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_cmd(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input int waits, input bit hang);
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [3:0]  exp_strb;
        int          exp_acc;
        int          acc;
        bit          done;
        int          guard;

        exp_err   = (addr >= 8'hC0);
        exp_rdata = wr ? 32'h0 : ref_mem[addr];
        exp_strb  = wr ? strb : 4'h0;
        exp_acc   = waits + 1;
        if (hang) begin
            exp_err   = 1'b1;
            exp_rdata = 32'h0;
            exp_acc   = TIMEOUT;
        end else if (wr && !exp_err) begin
            for (int i = 0; i < 4; i++)
                if (strb[i]) ref_mem[addr][8*i +: 8] = wdata[8*i +: 8];
        end

        guard = 0;
        while (!cmd_ready && guard < 20) begin
            @(negedge PCLK);
            guard++;
        end
        check("ready_before_cmd", cmd_ready, 1'b1);

        slave_waits = waits;
        slave_hang  = hang;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_strb  = strb;

        @(negedge PCLK);
        check("setup_sel_en", {PSEL, PENABLE}, 2'b10);
        check("setup_pwrite", PWRITE, wr);
        check("setup_paddr", PADDR, addr);
        check("setup_pstrb", PSTRB, exp_strb);
        if (wr) check("setup_pwdata", PWDATA, wdata);
        check("setup_ready_low", cmd_ready, 1'b0);

        // Junk command held while busy: must be ignored, not queued.
        cmd_write = 1'($urandom);
        cmd_addr  = 8'($urandom);
        cmd_wdata = $urandom;
        cmd_strb  = 4'($urandom);

        acc  = 0;
        done = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge PCLK);
            if (rsp_valid) begin
                done = 1'b1;
                break;
            end
            acc++;
            check("access_sel_en", {PSEL, PENABLE}, 2'b11);
            check("access_paddr", PADDR, addr);
            check("access_pstrb", PSTRB, exp_strb);
            check("access_ready_low", cmd_ready, 1'b0);
        end
        cmd_valid = 1'b0;

        check("rsp_seen", done, 1'b1);
        check("access_cycles", acc, exp_acc);
        check("rsp_err", rsp_err, exp_err);
        check("rsp_rdata", rsp_rdata, exp_rdata);
        check("rsp_sel_en_low", {PSEL, PENABLE}, 2'b00);
        check("rsp_ready", cmd_ready, 1'b1);
        last_rdata = rsp_rdata;
        last_err   = rsp_err;

        @(negedge PCLK);
        check("rsp_pulse_end", rsp_valid, 1'b0);
        check("rsp_rdata_hold", rsp_rdata, exp_rdata);
        check("rsp_err_hold", rsp_err, exp_err);
        check("no_queued_cmd", PSEL, 1'b0);
        slave_hang = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] a;
        for (int i = 0; i < 256; i++) begin
            slv_mem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end

        // Reset values
        #2 PRESETn = 1'b0;
        #1;
        check("rst_psel", PSEL, 1'b0);
        check("rst_penable", PENABLE, 1'b0);
        check("rst_pwrite", PWRITE, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_err", rsp_err, 1'b0);
        check("rst_cmd_ready", cmd_ready, 1'b0);
        check("rst_paddr", PADDR, 8'h0);
        check("rst_pstrb", PSTRB, 4'h0);
        check("rst_pwdata", PWDATA, 32'h0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        @(negedge PCLK);
        @(negedge PCLK);
        check("rst_hold_ready", cmd_ready, 1'b0);
        PRESETn = 1'b1;
        #1 check("rst_release_ready_low", cmd_ready, 1'b0);
        @(negedge PCLK);
        check("rst_first_edge_ready", cmd_ready, 1'b1);

        // Full write with a 4-wait-state slave
        do_cmd(1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 4, 1'b0);
        check("wr_err_low", last_err, 1'b0);
        // Readback
        do_cmd(1'b0, 8'h10, 32'h0, 4'h0, 1, 1'b0);
        check("readback_value", last_rdata, 32'hDEADBEEF);
        // Partial-strobe write then read
        do_cmd(1'b1, 8'h10, 32'h12345678, 4'h3, 0, 1'b0);
        do_cmd(1'b0, 8'h10, 32'h0, 4'h0, 2, 1'b0);
        check("partial_strb_value", last_rdata, 32'hDEAD5678);
        // Slave error region
        do_cmd(1'b1, 8'hC4, 32'hCAFEF00D, 4'hF, 2, 1'b0);
        check("slverr_flag", last_err, 1'b1);

        // Random traffic, biased toward a small address window so reads hit writes
        for (int n = 0; n < 40; n++) begin
            a = ($urandom_range(0, 2) != 0) ? {4'h1, 4'($urandom)} : 8'($urandom);
            do_cmd(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 5), 1'b0);
        end

`ifdef APB_TIMEOUT_EN
        do_cmd(1'b0, 8'h20, 32'h0, 4'h0, 0, 1'b1);
        check("timeout_err", last_err, 1'b1);
`endif

        // Reset during ACCESS
        slave_hang = 1'b1;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 8'h10;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        repeat (3) @(negedge PCLK);
        check("abort_in_access", {PSEL, PENABLE}, 2'b11);
        #2 PRESETn = 1'b0;
        #1;
        check("abort_sel_en", {PSEL, PENABLE}, 2'b00);
        check("abort_rsp_valid", rsp_valid, 1'b0);
        check("abort_ready_low", cmd_ready, 1'b0);
        @(negedge PCLK);
        check("abort_hold_rsp", rsp_valid, 1'b0);
        PRESETn = 1'b1;
        slave_hang = 1'b0;
        #1 check("abort_release_ready_low", cmd_ready, 1'b0);
        @(negedge PCLK);
        check("abort_ready_after_edge", cmd_ready, 1'b1);
        check("abort_no_rsp", rsp_valid, 1'b0);
        check("abort_psel_low", PSEL, 1'b0);

        // Traffic still works after the abort
        do_cmd(1'b0, 8'h10, 32'h0, 4'h0, 3, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_cmd_master.md
APB_CMD_MASTER -- requirements
Module: apb_cmd_master

Interface
REQ-001: The block SHALL use one clock and an asynchronous, active-low reset, named PCLK and PRESETn.
REQ-002: Parameter ADDR_WIDTH, default 8: width of cmd_addr and PADDR.
REQ-003: Parameter DATA_WIDTH, default 32: width of data buses; PSTRB width is DATA_WIDTH/8.
REQ-004: Parameter TIMEOUT, default 16: maximum ACCESS-phase cycles before abort; used only when APB_TIMEOUT_EN is defined.
REQ-005: Ports SHALL be as follows:
- PCLK  in  1  clock.
- PRESETn  in  1  async active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  master idle, can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  target address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_strb  in  DATA_WIDTH/8  byte strobes.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DATA_WIDTH  read data.
- rsp_err  out  1  slave error or timeout.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  ADDR_WIDTH  APB address.
- PSTRB  out  DATA_WIDTH/8  APB strobes.
- PWDATA  out  DATA_WIDTH  APB write data.
- PRDATA  in  DATA_WIDTH  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB error.

Function
REQ-006: The FSM SHALL have three states, IDLE, SETUP and ACCESS; all outputs SHALL be registered.
REQ-007: cmd_ready SHALL be 1 exactly when the state is IDLE; the master SHALL accept a command on a clock edge where cmd_valid and cmd_ready are both 1.
REQ-008: On acceptance, the FSM SHALL latch cmd_write, cmd_addr, cmd_wdata and cmd_strb, and SHALL go to SETUP with PSEL=1 and PENABLE=0 from the next cycle.
REQ-009: SETUP SHALL last exactly one cycle, then go to ACCESS with PSEL=1 and PENABLE=1.
REQ-010: In ACCESS, PSEL, PENABLE, PWRITE, PADDR, PSTRB and PWDATA SHALL hold stable until PREADY=1 is sampled.
REQ-011: On the edge where PREADY=1 is sampled in ACCESS, the master SHALL:
- capture PSLVERR into rsp_err;
- capture PRDATA into rsp_rdata for reads, or load 0 for writes;
- pulse rsp_valid for one cycle;
- return to IDLE with PSEL=0 and PENABLE=0.
REQ-012: PREADY and PSLVERR SHALL be ignored outside ACCESS.
REQ-013: For reads, PSTRB SHALL be driven to 0; for writes it SHALL equal the latched cmd_strb.
REQ-014: rsp_rdata and rsp_err SHALL hold their values until the next response.
REQ-015: The minimum period between accepted commands SHALL be 3 cycles plus the slave wait cycles; there is no response back-pressure.
REQ-016: cmd_valid asserted while cmd_ready=0 SHALL be ignored and SHALL not be queued.

Reset
REQ-017: While PRESETn=0, the block SHALL hold:
- the state at IDLE;
- PSEL, PENABLE, PWRITE, rsp_valid, rsp_err and cmd_ready at 0;
- PADDR, PSTRB, PWDATA and rsp_rdata at 0.
REQ-018: cmd_ready SHALL rise on the first PCLK edge after PRESETn deasserts.
REQ-019: Reset asserted mid-transfer SHALL abort the transfer immediately, with no rsp_valid pulse for the aborted command.

Configuration
REQ-020: With APB_TIMEOUT_EN defined:
- a counter SHALL clear on entry to ACCESS and increment each ACCESS cycle with PREADY=0;
- when the count reaches TIMEOUT, the FSM SHALL go to IDLE and pulse rsp_valid with rsp_err=1 and rsp_rdata=0.
REQ-021: Without APB_TIMEOUT_EN, ACCESS SHALL wait indefinitely for PREADY and the counter SHALL not exist.

Verification
REQ-022: The bench SHALL cover a full write: write addr 0x10, data 0xDEADBEEF, strb 0xF, with a 4-wait-state slave -> PSEL/PENABLE sequence 10,11 (held until PREADY), rsp_valid pulse, rsp_err=0.
REQ-023: The bench SHALL cover readback: read addr 0x10 -> PSTRB=0 during the transfer, rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-024: The bench SHALL cover a partial-strobe write: write 0x12345678 to 0x10 with strb 0x3, then read 0x10 -> rsp_rdata=0xDEAD5678.
REQ-025: The bench SHALL cover a slave error: write addr 0xC4 to a slave that flags addresses 0xC0-0xFF -> rsp_err=1, with cmd_ready back to 1 on the cycle after the response.
REQ-026: The bench SHALL cover timeout (APB_TIMEOUT_EN defined, TIMEOUT=16): hold PREADY=0 -> rsp_valid with rsp_err=1 after 16 ACCESS cycles.
REQ-027: The bench SHALL cover reset mid-transfer: assert PRESETn=0 during ACCESS -> PSEL=PENABLE=0 immediately, no rsp_valid, cmd_ready=1 on the first edge after release.
